countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Sequencing controller for an MM:SS countdown built from two external 00–59 BCD down-counters: one for seconds and one for minutes. The block holds the user preset and loads it into both counters. It gates the 1 Hz tick into the seconds counter and chains the seconds borrow into the minutes counter. It detects 00:00, raises a time-limited alarm and handles start/pause/clear buttons.

## Interface
- ALARM_SECS, default 10: number of tick_1hz pulses the alarm stays asserted before auto-return to IDLE (1–255).
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse, once per second
- btn_start  in  1  one-cycle pulse (debounced upstream), start/pause toggle
- btn_clear  in  1  one-cycle pulse, abort and return to IDLE
- btn_inc_min  in  1  one-cycle pulse, preset minutes +1 (IDLE only)
- btn_inc_sec  in  1  one-cycle pulse, preset seconds +1 (IDLE only)
- sec_tens, sec_ones, min_tens, min_ones  in  4 each  current BCD values from the seconds/minutes counters
- sec_borrow  in  1  borrow pulse from the seconds counter
- sec_load, min_load  out  1 each  synchronous load strobes to the counters
- sec_en, min_en  out  1 each  count-enable to the counters
- pre_sec_tens, pre_sec_ones, pre_min_tens, pre_min_ones  out  4 each  preset value, wired to the counters' load inputs
- running  out  1  state == RUN
- alarm  out  1  state == ALARM

## Operation
- States: IDLE, RUN, PAUSE, ALARM. Held in a registered FSM; reset → IDLE.
- Preset registers hold minutes and seconds, each as 2-digit BCD with a valid range of 00–59. Reset value is 00:00.
- IDLE:
  - sec_load = min_load = 1 every cycle, so the counters mirror the preset.
  - btn_inc_sec increments preset seconds in BCD: x9 → (x+1)0, and 59 → 00. btn_inc_min does the same for preset minutes. The two buttons in the same cycle both apply.
  - btn_clear sets the preset to 00:00.
  - btn_start with preset ≠ 00:00 → RUN. btn_start with preset == 00:00 is ignored.
- RUN:
  - sec_en = tick_1hz, masked when btn_start or btn_clear is active in the same cycle.
  - btn_start → PAUSE. btn_clear → IDLE; the preset is kept, so the counters reload it.
  - When all four counter inputs read 0 and sec_borrow = 0 → ALARM. This check takes priority over btn_start in the same cycle. btn_clear still wins.
- PAUSE: sec_en = 0. btn_start → RUN, btn_clear → IDLE.
- min_en = sec_borrow whenever the state is RUN or PAUSE. A borrow pending at the moment of pausing is therefore not lost. min_en = 0 in IDLE and ALARM.
- ALARM:
  - An internal 8-bit counter is cleared on entry and incremented on each tick_1hz.
  - On reaching ALARM_SECS → IDLE.
  - Any button pulse (start, clear, inc_min, inc_sec) → IDLE immediately. The button's normal IDLE function is not applied in that cycle.
- Button priority in every state: btn_clear > btn_start > inc buttons.
- The inc buttons are ignored outside IDLE.

## Timing
- Reset: while rst_n = 0 at a clk edge, all state is forced at that edge: state IDLE, preset 00:00, alarm counter 0. The cycle after reset, outputs are:
  - running = 0, alarm = 0
  - sec_en = min_en = 0
  - sec_load = min_load = 1
  - pre_* = 0
- A reset asserted mid-RUN or mid-ALARM takes effect on the next edge and discards the preset.
- sec_en, min_en, sec_load and min_load are combinational from the registered state plus same-cycle inputs; latency 0.
- running and alarm are decoded from the registered state: one cycle after the causing input.
- Preset updates are visible on pre_* one cycle after the button pulse. The counters load them on the following edge.
- Minute rollover, e.g. 01:00 + tick:
  - The counters show 01:59 for exactly one cycle.
  - sec_borrow drives min_en in that cycle.
  - The display then shows 00:59.
  - Zero detection is not triggered by the transient.
- 00:01 + tick: the counters read 00:00 on the next cycle. ALARM is entered on the edge after that, and no further sec_en is issued.

## Test plan
- Reset with rst_n = 0 for 2 cycles → running = 0, alarm = 0, sec_load = min_load = 1, pre_* = 00:00, en outputs 0.
- In IDLE, apply 3×inc_min and 61×inc_sec → preset 03:01 (seconds wrapped 59 → 00). Then btn_start with preset 00:00 after a clear → stays IDLE.
- Preset 01:02, start, then 62 ticks → the sequence 01:01, 01:00, 00:59 … 00:00 is observed. min_en fires exactly once. ALARM is entered 2 cycles after the final tick, and alarm returns to 0 after 10 more ticks with the counters reloaded to 01:02.
- In RUN, btn_start coincident with tick_1hz → sec_en = 0 and PAUSE is entered. Further ticks are ignored. btn_start again → RUN and counting resumes from the same value.
- Pause in the cycle sec_borrow is high (01:00 → 00:59) → min_en still asserts and minutes show 00.
- In ALARM, press btn_inc_sec → IDLE the next cycle with the preset unchanged. In RUN, btn_clear together with btn_start → IDLE, not PAUSE.

Source files
------------

// File: rtl/countdown_ctrl.sv
// MM:SS countdown sequencer: owns the preset, gates the 1 Hz tick into two
// external BCD down-counters and runs the IDLE/RUN/PAUSE/ALARM control FSM.
module countdown_ctrl #(
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic       sec_borrow,
  output logic       sec_load,
  output logic       min_load,
  output logic       sec_en,
  output logic       min_en,
  output logic [3:0] pre_sec_tens,
  output logic [3:0] pre_sec_ones,
  output logic [3:0] pre_min_tens,
  output logic [3:0] pre_min_ones,
  output logic       running,
  output logic       alarm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [7:0] ALARM_LIM = 8'(ALARM_SECS);

  state_t     state, state_nxt;
  logic [7:0] pre_sec, pre_sec_nxt;
  logic [7:0] pre_min, pre_min_nxt;
  logic [7:0] acnt, acnt_nxt;
  logic       cnt_zero;
  logic       any_btn;

  // Two-digit BCD increment over 00..59; anything at or above 59 wraps to 00.
  function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
    logic [7:0] r;
    if (v >= 8'h59)
      r = 8'h00;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // A pending borrow means the minutes counter is about to change, so a
  // momentary 00 in the digits is not a real expiry.
  assign cnt_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000) && !sec_borrow;
  assign any_btn  = btn_start | btn_clear | btn_inc_min | btn_inc_sec;

  always_comb begin
    state_nxt   = state;
    pre_sec_nxt = pre_sec;
    pre_min_nxt = pre_min;
    acnt_nxt    = 8'd0;
    sec_load    = 1'b0;
    min_load    = 1'b0;
    sec_en      = 1'b0;
    min_en      = 1'b0;
    case (state)
      IDLE: begin
        sec_load = 1'b1;
        min_load = 1'b1;
        if (btn_clear) begin
          pre_sec_nxt = 8'h00;
          pre_min_nxt = 8'h00;
        end else if (btn_start) begin
          if ({pre_min, pre_sec} != 16'h0000)
            state_nxt = RUN;
        end else begin
          if (btn_inc_sec)
            pre_sec_nxt = bcd_inc59(pre_sec);
          if (btn_inc_min)
            pre_min_nxt = bcd_inc59(pre_min);
        end
      end
      RUN: begin
        sec_en = tick_1hz && !btn_start && !btn_clear && !cnt_zero;
        min_en = sec_borrow;
        if (btn_clear)
          state_nxt = IDLE;
        else if (cnt_zero)
          state_nxt = ALARM;
        else if (btn_start)
          state_nxt = PAUSE;
      end
      PAUSE: begin
        min_en = sec_borrow;
        if (btn_clear)
          state_nxt = IDLE;
        else if (btn_start)
          state_nxt = RUN;
      end
      ALARM: begin
        acnt_nxt = acnt;
        if (any_btn) begin
          state_nxt = IDLE;
        end else if (tick_1hz) begin
          acnt_nxt = acnt + 8'd1;
          if ((acnt + 8'd1) >= ALARM_LIM)
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre_sec <= 8'h00;
      pre_min <= 8'h00;
      acnt    <= 8'd0;
    end else begin
      state   <= state_nxt;
      pre_sec <= pre_sec_nxt;
      pre_min <= pre_min_nxt;
      acnt    <= acnt_nxt;
    end
  end

  assign pre_sec_tens = pre_sec[7:4];
  assign pre_sec_ones = pre_sec[3:0];
  assign pre_min_tens = pre_min[7:4];
  assign pre_min_ones = pre_min[3:0];
  assign running      = (state == RUN);
  assign alarm        = (state == ALARM);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl, with a behavioural pair of BCD
// down-counters standing in for the external seconds/minutes counters.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_inc_min = 1'b0;
  logic       btn_inc_sec = 1'b0;
  logic       sec_borrow = 1'b0;
  logic [7:0] csec = 8'h00;
  logic [7:0] cmin = 8'h00;
  logic       sec_load, min_load, sec_en, min_en, running, alarm;
  logic [3:0] pre_sec_tens, pre_sec_ones, pre_min_tens, pre_min_ones;
  logic [15:0] pre, disp;
  int tests = 0;
  int fails = 0;
  int min_en_cnt = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(.ALARM_SECS(10)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_start(btn_start), .btn_clear(btn_clear),
    .btn_inc_min(btn_inc_min), .btn_inc_sec(btn_inc_sec),
    .sec_tens(csec[7:4]), .sec_ones(csec[3:0]),
    .min_tens(cmin[7:4]), .min_ones(cmin[3:0]),
    .sec_borrow(sec_borrow),
    .sec_load(sec_load), .min_load(min_load),
    .sec_en(sec_en), .min_en(min_en),
    .pre_sec_tens(pre_sec_tens), .pre_sec_ones(pre_sec_ones),
    .pre_min_tens(pre_min_tens), .pre_min_ones(pre_min_ones),
    .running(running), .alarm(alarm)
  );

  assign pre  = {pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones};
  assign disp = {cmin, csec};

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00) return 8'h59;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // External counters: seconds borrow is a registered pulse after 00 -> 59.
  always @(posedge clk) begin
    sec_borrow <= 1'b0;
    if (sec_load === 1'b1)
      csec <= {pre_sec_tens, pre_sec_ones};
    else if (sec_en === 1'b1) begin
      csec <= bcd_dec(csec);
      if (csec == 8'h00) sec_borrow <= 1'b1;
    end
    if (min_load === 1'b1)
      cmin <= {pre_min_tens, pre_min_ones};
    else if (min_en === 1'b1)
      cmin <= bcd_dec(cmin);
    if (min_en === 1'b1) min_en_cnt <= min_en_cnt + 1;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick_gap();
    tick_1hz = 1'b1;
    next();
    tick_1hz = 1'b0;
    next();
    next();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    next();
    next();
    rst_n = 1'b1;
    chk("rst_running", 16'(running), 16'h0);
    chk("rst_alarm", 16'(alarm), 16'h0);
    chk("rst_loads", 16'({sec_load, min_load}), 16'h3);
    chk("rst_ens", 16'({sec_en, min_en}), 16'h0);
    chk("rst_pre", pre, 16'h0000);

    // Preset editing, both inc buttons together, seconds wrap
    for (int i = 0; i < 3; i++) begin
      btn_inc_min = 1'b1;
      btn_inc_sec = 1'b1;
      next();
      btn_inc_min = 1'b0;
      btn_inc_sec = 1'b0;
    end
    chk("inc_both", pre, 16'h0303);
    for (int i = 0; i < 58; i++) begin
      btn_inc_sec = 1'b1;
      next();
      btn_inc_sec = 1'b0;
      if (i == 56) chk("inc_wrap", pre, 16'h0300);
    end
    chk("inc_final", pre, 16'h0301);
    next();
    chk("idle_mirror", disp, 16'h0301);

    // Clear, then start on 00:00 is ignored
    btn_clear = 1'b1;
    next();
    btn_clear = 1'b0;
    chk("clear_pre", pre, 16'h0000);
    btn_start = 1'b1;
    next();
    btn_start = 1'b0;
    chk("start_zero", 16'(running), 16'h0);

    // Full countdown from 01:02
    btn_inc_min = 1'b1;
    btn_inc_sec = 1'b1;
    next();
    btn_inc_min = 1'b0;
    next();
    btn_inc_sec = 1'b0;
    chk("pre_0102", pre, 16'h0102);
    btn_start = 1'b1;
    next();
    btn_start = 1'b0;
    chk("run_start", 16'(running), 16'h1);
    chk("run_disp", disp, 16'h0102);
    chk("run_noload", 16'({sec_load, min_load}), 16'h0);
    min_en_cnt = 0;
    tick_1hz = 1'b1;
    #1;
    chk("sec_en_tick", 16'(sec_en), 16'h1);
    tick_1hz = 1'b0;
    for (int i = 1; i <= 61; i++) begin
      if (i > 1) tick_gap();
      else begin
        tick_1hz = 1'b1;
        next();
        tick_1hz = 1'b0;
        next();
        next();
      end
      if (i == 1) chk("cd_0101", disp, 16'h0101);
      if (i == 2) chk("cd_0100", disp, 16'h0100);
      if (i == 3) chk("cd_0059", disp, 16'h0059);
      if (i == 61) chk("cd_0001", disp, 16'h0001);
    end
    chk("cd_running", 16'(running), 16'h1);
    tick_1hz = 1'b1;
    next();
    tick_1hz = 1'b0;
    chk("cd_0000", disp, 16'h0000);
    chk("cd_noalarm_yet", 16'(alarm), 16'h0);
    tick_1hz = 1'b1;
    #1;
    chk("zero_sec_en_mask", 16'(sec_en), 16'h0);
    next();
    tick_1hz = 1'b0;
    chk("alarm_on", 16'(alarm), 16'h1);
    chk("alarm_notrun", 16'(running), 16'h0);
    chk("min_en_once", 16'(min_en_cnt), 16'h1);

    // Alarm lasts ten ticks, then counters reload the preset
    for (int i = 1; i <= 10; i++) begin
      tick_1hz = 1'b1;
      next();
      tick_1hz = 1'b0;
      next();
      if (i == 9) chk("alarm_hold9", 16'(alarm), 16'h1);
    end
    chk("alarm_off", 16'(alarm), 16'h0);
    chk("alarm_reload", disp, 16'h0102);

    // Pause on a tick cycle, ticks ignored, resume
    btn_start = 1'b1;
    next();
    btn_start = 1'b0;
    chk("p_run", 16'(running), 16'h1);
    tick_gap();
    chk("p_0101", disp, 16'h0101);
    tick_1hz = 1'b1;
    btn_start = 1'b1;
    #1;
    chk("p_sec_en_mask", 16'(sec_en), 16'h0);
    next();
    tick_1hz = 1'b0;
    btn_start = 1'b0;
    chk("p_paused", 16'(running), 16'h0);
    tick_gap();
    tick_gap();
    chk("p_hold", disp, 16'h0101);
    btn_start = 1'b1;
    next();
    btn_start = 1'b0;
    chk("p_resume", 16'(running), 16'h1);
    tick_gap();
    chk("p_0100", disp, 16'h0100);

    // Pause while the borrow is pending
    tick_1hz = 1'b1;
    next();
    tick_1hz = 1'b0;
    chk("b_transient", disp, 16'h0159);
    btn_start = 1'b1;
    #1;
    chk("b_min_en", 16'(min_en), 16'h1);
    next();
    btn_start = 1'b0;
    chk("b_disp", disp, 16'h0059);
    chk("b_paused", 16'(running), 16'h0);
    tick_1hz = 1'b1;
    #1;
    chk("b_pause_sec_en", 16'(sec_en), 16'h0);
    next();
    tick_1hz = 1'b0;

    // Clear from PAUSE keeps preset; then reach ALARM from 00:01
    btn_clear = 1'b1;
    next();
    btn_clear = 1'b0;
    chk("pc_idle", 16'({running, alarm}), 16'h0);
    chk("pc_pre", pre, 16'h0102);
    btn_clear = 1'b1;
    next();
    btn_clear = 1'b0;
    btn_inc_sec = 1'b1;
    next();
    btn_inc_sec = 1'b0;
    btn_start = 1'b1;
    next();
    btn_start = 1'b0;
    chk("a_run", 16'(running), 16'h1);
    tick_1hz = 1'b1;
    next();
    tick_1hz = 1'b0;
    next();
    chk("a_alarm", 16'(alarm), 16'h1);
    btn_inc_sec = 1'b1;
    next();
    btn_inc_sec = 1'b0;
    chk("a_btn_exit", 16'({running, alarm}), 16'h0);
    chk("a_pre_kept", pre, 16'h0001);

    // Clear beats start in RUN
    btn_start = 1'b1;
    next();
    btn_start = 1'b0;
    chk("cs_run", 16'(running), 16'h1);
    btn_clear = 1'b1;
    btn_start = 1'b1;
    next();
    btn_clear = 1'b0;
    btn_start = 1'b0;
    chk("cs_idle", 16'({running, alarm}), 16'h0);
    chk("cs_loads", 16'({sec_load, min_load}), 16'h3);
    chk("cs_pre", pre, 16'h0001);

    // Reset mid-RUN discards the preset
    btn_start = 1'b1;
    next();
    btn_start = 1'b0;
    chk("r_run", 16'(running), 16'h1);
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    chk("r_running", 16'(running), 16'h0);
    chk("r_pre", pre, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
